// File: rtl/ks_add_seq.sv
// Slice-serial adder sequencer: streams WIDTH-bit operands LSB-first through
// an external 8-bit adder, chains the carry and returns the assembled result
// over a valid/ready interface.
module ks_add_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c0,
    output logic [7:0]       o_add_a,
    output logic [7:0]       o_add_b,
    output logic             o_add_c0,
    input  logic [7:0]       i_add_sum,
    input  logic             i_add_c,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_busy
);

    localparam int unsigned N  = WIDTH / 8;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             accept;

    assign o_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & i_ready);
    assign accept  = i_valid & o_ready;

    assign o_valid  = (state_q == S_DONE);
    assign o_busy   = (state_q == S_RUN);
    assign o_add_a  = (state_q == S_RUN) ? a_q[{k_q, 3'b000} +: 8] : '0;
    assign o_add_b  = (state_q == S_RUN) ? b_q[{k_q, 3'b000} +: 8] : '0;
    assign o_add_c0 = (state_q == S_RUN) ? carry_q : 1'b0;
    assign o_sum    = sum_q;
    assign o_cout   = cout_q;
    assign o_ovf    = ovf_q;

    // State register and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: accept, per-slice accumulate, final publish, retire.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    carry_d = i_c0;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d[{k_q, 3'b000} +: 8] = i_add_sum;
                carry_d = i_add_c;
                if (k_q == K_LAST) begin
                    // Output registers are loaded only here so o_sum never shows partial slices.
                    sum_d   = acc_d;
                    cout_d  = i_add_c;
                    ovf_d   = i_add_c ^ (i_add_sum[7] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    if (i_valid) begin
                        a_d     = i_a;
                        b_d     = i_b;
                        carry_d = i_c0;
                        k_d     = '0;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ks_add_seq.sv
// Bench for ks_add_seq (WIDTH=32) with a behavioural 8-bit adder attached.
module tb_ks_add_seq;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_c0;
    logic [7:0]  o_add_a;
    logic [7:0]  o_add_b;
    logic        o_add_c0;
    logic [7:0]  i_add_sum;
    logic        i_add_c;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_sum;
    logic        o_cout;
    logic        o_ovf;
    logic        o_busy;

    int n_cmp;
    int n_bad;

    ks_add_seq #(.WIDTH(32)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_c0      (i_c0),
        .o_add_a   (o_add_a),
        .o_add_b   (o_add_b),
        .o_add_c0  (o_add_c0),
        .i_add_sum (i_add_sum),
        .i_add_c   (i_add_c),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sum     (o_sum),
        .o_cout    (o_cout),
        .o_ovf     (o_ovf),
        .o_busy    (o_busy)
    );

    // External 8-bit adder.
    assign {i_add_c, i_add_sum} = {1'b0, o_add_a} + {1'b0, o_add_b} + {8'b0, o_add_c0};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c0;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  c0seq;  // bit k = expected o_add_c0 in RUN cycle k
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic c0);
        logic [32:0] s;
        logic        ov;
        s  = {1'b0, a} + {1'b0, b} + {32'b0, c0};
        ov = (a[31] == b[31]) && (s[31] != a[31]);
        return {ov, s};
    endfunction

    // Starts at a negedge in IDLE; returns #1 after the accept edge.
    task automatic accept(input vec_t v);
        @(posedge i_clk);
        #1;
        i_a = v.a; i_b = v.b; i_c0 = v.c0; i_valid = 1'b1;
        @(negedge i_clk);
        chk("accept_ready", {31'b0, o_ready}, 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_a = $urandom; i_b = $urandom; i_c0 = 1'b1;
    endtask

    // Called #1 after the accept edge; ends at a negedge in DONE.
    task automatic run_check(input vec_t v);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk($sformatf("run_busy_k%0d", k), {31'b0, o_busy}, 32'd1);
            chk($sformatf("run_valid_k%0d", k), {31'b0, o_valid}, 32'd0);
            chk($sformatf("run_c0_k%0d", k), {31'b0, o_add_c0}, {31'b0, v.c0seq[k]});
            @(posedge i_clk);
        end
        @(negedge i_clk);
        chk("done_valid", {31'b0, o_valid}, 32'd1);
        chk("done_busy", {31'b0, o_busy}, 32'd0);
        chk("done_sum", o_sum, v.sum);
        chk("done_cout", {31'b0, o_cout}, {31'b0, v.cout});
        chk("done_ovf", {31'b0, o_ovf}, {31'b0, v.ovf});
    endtask

    // Called at a negedge in DONE; retires the result with no new request.
    task automatic retire(input vec_t v);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        @(negedge i_clk);
        chk("retire_valid", {31'b0, o_valid}, 32'd0);
        chk("retire_ready", {31'b0, o_ready}, 32'd1);
        chk("retire_hold_sum", o_sum, v.sum);
        chk("retire_add_a", {24'b0, o_add_a}, 32'd0);
    endtask

    logic [33:0] q[$];

    initial begin
        vec_t v_hold;
        vec_t v_ff;
        vec_t v_abort;
        logic [33:0] exp_r;
        int accepted;
        int results;
        int cyc;

        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 4'b0001};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 4'b1110};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 4'b1110};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 4'b0000};
        vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 4'b0000};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'b1111};
        v_hold  = '{32'h1234_5678, 32'h0000_0001, 1'b0, 32'h1234_5679, 1'b0, 1'b0, 4'b0000};
        v_ff    = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 4'b0010};
        v_abort = '{32'h1111_1111, 32'h2222_2222, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 4'b0000};

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_a = '0; i_b = '0; i_c0 = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_ready", {31'b0, o_ready}, 32'd1);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_sum", o_sum, 32'd0);
        chk("rst_cout_ovf", {30'b0, o_cout, o_ovf}, 32'd0);
        chk("rst_add", {15'b0, o_add_c0, o_add_a, o_add_b}, 32'd0);

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            accept(vecs[i]);
            run_check(vecs[i]);
            retire(vecs[i]);
        end

        // Back-pressure in DONE, then same-cycle retire and accept.
        accept(v_hold);
        run_check(v_hold);
        i_valid = 1'b1; i_a = v_ff.a; i_b = v_ff.b; i_c0 = v_ff.c0; i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            chk("hold_valid", {31'b0, o_valid}, 32'd1);
            chk("hold_ready", {31'b0, o_ready}, 32'd0);
            chk("hold_sum", o_sum, v_hold.sum);
        end
        i_ready = 1'b1;
        #1;
        chk("b2b_ready", {31'b0, o_ready}, 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0; i_ready = 1'b0;
        i_a = $urandom; i_b = $urandom;
        run_check(v_ff);
        retire(v_ff);

        // Reset while in RUN at k=2.
        accept(v_abort);
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            @(posedge i_clk);
        end
        @(negedge i_clk);
        chk("abort_busy_k2", {31'b0, o_busy}, 32'd1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("abort_ready", {31'b0, o_ready}, 32'd1);
        chk("abort_valid", {31'b0, o_valid}, 32'd0);
        chk("abort_busy", {31'b0, o_busy}, 32'd0);
        chk("abort_sum", o_sum, 32'd0);
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            chk("abort_no_result", {31'b0, o_valid}, 32'd0);
        end
        i_ready = 1'b0;

        // Random traffic against a scoreboard.
        accepted = 0;
        results  = 0;
        cyc      = 0;
        while (results < 1000 && cyc < 60000) begin
            @(posedge i_clk);
            #1;
            cyc++;
            i_valid = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       i_a = 32'hFFFF_FFFF;
                1:       i_a = 32'h8000_0000;
                default: i_a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       i_b = 32'h0000_0001;
                1:       i_b = 32'h7FFF_FFFF;
                default: i_b = $urandom;
            endcase
            i_c0    = 1'($urandom_range(0, 1));
            i_ready = ($urandom_range(0, 2) != 0);
            @(negedge i_clk);
            if (o_valid && i_ready) begin
                results++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rand_extra: got result %h with no request outstanding, expected none", o_sum);
                end else begin
                    exp_r = q.pop_front();
                    chk("rand_sum", o_sum, exp_r[31:0]);
                    chk("rand_cout", {31'b0, o_cout}, {31'b0, exp_r[32]});
                    chk("rand_ovf", {31'b0, o_ovf}, {31'b0, exp_r[33]});
                end
            end
            if (i_valid && o_ready) begin
                q.push_back(ref_add(i_a, i_b, i_c0));
                accepted++;
            end
        end
        chk("rand_results", results, 32'd1000);
        chk("rand_queue_empty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
